// File: rtl/sd_cache_pkg.sv
// -----------------------------------------------------------------------------
// sd_cache_pkg
// Shared types and constants for the SD sector cache.
//   SECTOR_BYTES / ADDR_W : sector size and byte-index width
//   state_t               : controller FSM states
//   tag_t                 : bank tag {drive, lba}
//   drive_onehot()        : drive index -> one-hot read-start vector
// -----------------------------------------------------------------------------
package sd_cache_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int ADDR_W       = $clog2(SECTOR_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_STREAM,
        ST_FINISH
    } state_t;

    typedef struct packed {
        logic        drive;
        logic [31:0] lba;
    } tag_t;

    function automatic logic [1:0] drive_onehot(input logic drive);
        return drive ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sd_sector_cache_if.sv
// -----------------------------------------------------------------------------
// sd_sector_cache_if
// Sector request / read-back bus between the floppy controller and the cache.
//   req, req_drive, req_lba : one-cycle sector request (consumer -> cache)
//   busy, ack, err          : request status (cache -> consumer)
//   rd_addr, rd_data        : byte read port into the served sector
// master = floppy controller side, slave = cache side.
// -----------------------------------------------------------------------------
interface sd_sector_cache_if;

    logic        req;
    logic        req_drive;
    logic [31:0] req_lba;
    logic        busy;
    logic        ack;
    logic        err;
    logic [8:0]  rd_addr;
    logic [7:0]  rd_data;

    modport master (
        output req, req_drive, req_lba, rd_addr,
        input  busy, ack, err, rd_data
    );

    modport slave (
        input  req, req_drive, req_lba, rd_addr,
        output busy, ack, err, rd_data
    );

endinterface

// File: rtl/sd_cache_bank.sv
// -----------------------------------------------------------------------------
// sd_cache_bank
// One 512 x 8 sector buffer: single write port, single registered read port.
//   clk   : clock
//   we    : write enable
//   waddr : write byte index, wdata : write byte
//   raddr : read byte index,  rdata : byte at raddr, one cycle later
// -----------------------------------------------------------------------------
module sd_cache_bank
    import sd_cache_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [SECTOR_BYTES];

    // NOTE: the array has no reset so it maps onto block RAM; whether a bank
    // holds usable data is tracked by the valid bits in the controller.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sd_sector_cache.sv
// -----------------------------------------------------------------------------
// sd_sector_cache
// Two-bank sector cache between sd_card and the floppy controller. Requests
// tagged {drive, lba} are answered from a bank on a hit, fetched from sd_card
// on a miss, and the next sequential sector is optionally prefetched into the
// spare bank after every served request.
//   clk, resetn         : clock, synchronous active-low reset
//   invalidate          : pulse, drop all tags (image changed)
//   fdc                 : request / read-back bus (slave side)
//   sd_rstart           : per-drive one-hot read start, held until sd_rbusy
//   sd_rsector          : LBA for sd_card
//   sd_rbusy, sd_rdone  : sd_card busy / sector-complete pulse
//   sd_outen/addr/byte  : incoming byte stream from sd_card
// -----------------------------------------------------------------------------
module sd_sector_cache
    import sd_cache_pkg::*;
#(
    parameter int          PREFETCH = 1,
    parameter logic [31:0] TIMEOUT  = 32'd64000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              invalidate,
    sd_sector_cache_if.slave  fdc,
    output logic [1:0]        sd_rstart,
    output logic [31:0]       sd_rsector,
    input  logic              sd_rbusy,
    input  logic              sd_rdone,
    input  logic              sd_outen,
    input  logic [8:0]        sd_outaddr,
    input  logic [7:0]        sd_outbyte
);

    state_t      state;
    logic [1:0]  valid;
    tag_t        bank_tag [2];
    logic        active;        // bank seen through rd_addr
    logic        active_q;      // active aligned with the registered RAM output
    logic        target;        // bank being filled
    logic        busy_q, ack_q, err_q;
    logic        rd_ok;
    logic        pend;          // demand request latched during a prefetch
    tag_t        pend_tag;
    tag_t        fetch_tag;
    logic        fetch_demand;  // current fetch answers a demand request
    logic        fetch_inval;   // invalidate seen while this fetch was in flight
    tag_t        last_tag;      // last served tag, base for the prefetch
    logic [31:0] timer;

    logic [7:0]  bank_q  [2];
    logic [1:0]  bank_we;

    // Bank storage
    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = resetn && (state == ST_STREAM) && sd_outen && (target == 1'(b));

        sd_cache_bank u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (sd_outaddr),
            .wdata (sd_outbyte),
            .raddr (fdc.rd_addr),
            .rdata (bank_q[b])
        );
    end

    assign fdc.rd_data = rd_ok ? (active_q ? bank_q[1] : bank_q[0]) : 8'h00;
    assign fdc.busy    = busy_q;
    assign fdc.ack     = ack_q;
    assign fdc.err     = err_q;

    // Lookup and next-action decode
    tag_t req_tag, lookup_tag, pf_tag, launch_tag;
    logic hit0, hit1, hit_any, hit_bank, spare, pf_skip;
    logic serve_en, launch_en, launch_bank, launch_demand;

    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        req_tag       = '{drive: fdc.req_drive, lba: fdc.req_lba};
        lookup_tag    = pend ? pend_tag : req_tag;
        hit0          = valid[0] && (bank_tag[0] == lookup_tag);
        hit1          = valid[1] && (bank_tag[1] == lookup_tag);
        hit_any       = (hit0 || hit1) && !invalidate;   // invalidate beats a hit
        hit_bank      = hit1;
        spare         = ~active;
        pf_tag        = '{drive: last_tag.drive, lba: last_tag.lba + 32'd1};
        pf_skip       = (PREFETCH == 0) || (valid[spare] && (bank_tag[spare] == pf_tag));

        serve_en      = 1'b0;
        launch_en     = 1'b0;
        launch_demand = 1'b0;
        launch_bank   = spare;
        launch_tag    = pf_tag;

        if (state == ST_IDLE || state == ST_FINISH) begin
            if (fdc.req || pend) begin
                if (hit_any) begin
                    serve_en = 1'b1;
                end else begin
                    launch_en     = 1'b1;
                    launch_demand = 1'b1;
                    launch_tag    = lookup_tag;
                    // After a fill, the miss goes to the bank not holding the new tag.
                    launch_bank   = (state == ST_FINISH) ? ~target : spare;
                end
            end else if (ack_q && !pf_skip) begin
                launch_en = 1'b1;
            end
        end
    end

    // Controller
    // NOTE: sequential state uses non-blocking assignments only, so every
    // reader in this block sees the pre-edge value and ordering does not matter;
    // the trailing invalidate clear relies on last-assignment-wins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            valid        <= '0;
            bank_tag[0]  <= '0;
            bank_tag[1]  <= '0;
            active       <= 1'b0;
            active_q     <= 1'b0;
            target       <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            rd_ok        <= 1'b0;
            pend         <= 1'b0;
            pend_tag     <= '0;
            fetch_tag    <= '0;
            fetch_demand <= 1'b0;
            fetch_inval  <= 1'b0;
            last_tag     <= '0;
            timer        <= '0;
            sd_rstart    <= '0;
            sd_rsector   <= '0;
        end else begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            active_q <= active;
            rd_ok    <= 1'b1;

            case (state)
                ST_IDLE, ST_FINISH: begin
                    state <= ST_IDLE;
                    if (serve_en) begin
                        active   <= hit_bank;
                        ack_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        pend     <= 1'b0;
                        last_tag <= lookup_tag;
                    end
                    if (launch_en) begin
                        state               <= ST_ISSUE;
                        target              <= launch_bank;
                        valid[launch_bank]  <= 1'b0;
                        fetch_tag           <= launch_tag;
                        fetch_demand        <= launch_demand;
                        fetch_inval         <= 1'b0;
                        pend                <= 1'b0;
                        timer               <= '0;
                        sd_rstart           <= drive_onehot(launch_tag.drive);
                        sd_rsector          <= launch_tag.lba;
                        if (launch_demand) begin
                            busy_q <= 1'b1;
                        end
                    end
                end

                ST_ISSUE, ST_STREAM: begin
                    timer <= timer + 32'd1;
                    if (invalidate) begin
                        fetch_inval <= 1'b1;
                    end
                    // A request arriving during a prefetch waits for it to finish.
                    if (fdc.req && !busy_q) begin
                        pend     <= 1'b1;
                        pend_tag <= req_tag;
                        busy_q   <= 1'b1;
                    end

                    if (timer == TIMEOUT - 32'd1) begin
                        state     <= ST_IDLE;
                        sd_rstart <= '0;
                        busy_q    <= 1'b0;
                        pend      <= 1'b0;
                        if (fetch_demand || pend || (fdc.req && !busy_q)) begin
                            err_q <= 1'b1;
                        end
                    end else if (state == ST_ISSUE) begin
                        if (sd_rbusy) begin
                            sd_rstart <= '0;
                            state     <= ST_STREAM;
                        end
                    end else if (sd_rdone) begin
                        state            <= ST_FINISH;
                        bank_tag[target] <= fetch_tag;
                        valid[target]    <= !fetch_inval;
                        // Demand fetch, or a waiting request for exactly this sector.
                        if (fetch_demand || (pend && (pend_tag == fetch_tag))) begin
                            active   <= target;
                            ack_q    <= 1'b1;
                            busy_q   <= 1'b0;
                            pend     <= 1'b0;
                            last_tag <= fetch_tag;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase

            if (invalidate) begin
                valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sd_sector_cache.sv
// -----------------------------------------------------------------------------
// tb_sd_sector_cache
// Directed bench for sd_sector_cache. A behavioural sd_card model answers read
// starts with bytes (i ^ 8'hA0 ^ lba[7:0]). A second instance with a short
// timeout and a silent sd_card covers the timeout path.
// -----------------------------------------------------------------------------
module tb_sd_sector_cache;
    import sd_cache_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        invalidate;
    logic        sd_rbusy, sd_rdone, sd_outen;
    logic [8:0]  sd_outaddr;
    logic [7:0]  sd_outbyte;
    logic [1:0]  sd_rstart;
    logic [31:0] sd_rsector;

    logic [1:0]  sd_rstart_to;
    logic [31:0] sd_rsector_to;

    sd_sector_cache_if fdc ();
    sd_sector_cache_if fdc_to ();

    sd_sector_cache #(.PREFETCH(1), .TIMEOUT(32'd4000)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .invalidate (invalidate),
        .fdc        (fdc),
        .sd_rstart  (sd_rstart),
        .sd_rsector (sd_rsector),
        .sd_rbusy   (sd_rbusy),
        .sd_rdone   (sd_rdone),
        .sd_outen   (sd_outen),
        .sd_outaddr (sd_outaddr),
        .sd_outbyte (sd_outbyte)
    );

    sd_sector_cache #(.PREFETCH(1), .TIMEOUT(32'd100)) dut_to (
        .clk        (clk),
        .resetn     (resetn),
        .invalidate (1'b0),
        .fdc        (fdc_to),
        .sd_rstart  (sd_rstart_to),
        .sd_rsector (sd_rsector_to),
        .sd_rbusy   (1'b0),
        .sd_rdone   (1'b0),
        .sd_outen   (1'b0),
        .sd_outaddr (9'd0),
        .sd_outbyte (8'd0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sector_byte(input int i, input logic [31:0] lba);
        return 8'(i) ^ 8'hA0 ^ lba[7:0];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_req(input logic drive, input logic [31:0] lba, input logic inval);
        fdc.req       = 1'b1;
        fdc.req_drive = drive;
        fdc.req_lba   = lba;
        invalidate    = inval;
        tick();
        fdc.req    = 1'b0;
        invalidate = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // sd_card model: wait for a read start, stream one sector, pulse rdone.
    // Optionally injects a request at byte req_at or drops reset at byte rst_at.
    // Returns in the cycle after rdone (or after the reset edge).
    task automatic sd_fetch(input string tag, input logic [31:0] lba, input logic [1:0] exp_start,
                            input int req_at, input logic [31:0] mid_lba, input int rst_at);
        int n = 0;
        while (sd_rstart == 2'b00 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_rstart"}, 32'(sd_rstart), 32'(exp_start));
        check({tag, "_rsector"}, sd_rsector, lba);
        sd_rbusy = 1'b1;
        tick();
        check({tag, "_rstart_drop"}, 32'(sd_rstart), 32'd0);
        for (int i = 0; i < SECTOR_BYTES; i++) begin
            sd_outen   = 1'b1;
            sd_outaddr = 9'(i);
            sd_outbyte = sector_byte(i, lba);
            if (i == req_at) begin
                fdc.req       = 1'b1;
                fdc.req_drive = 1'b0;
                fdc.req_lba   = mid_lba;
            end
            if (i == rst_at) begin
                resetn = 1'b0;
            end
            tick();
            fdc.req = 1'b0;
            if (i == req_at) begin
                check({tag, "_mid_busy"}, 32'(fdc.busy), 32'd1);
            end
            if (i == rst_at) begin
                sd_outen = 1'b0;
                sd_rbusy = 1'b0;
                return;
            end
        end
        sd_outen = 1'b0;
        sd_rdone = 1'b1;
        tick();
        sd_rdone = 1'b0;
        sd_rbusy = 1'b0;
    endtask

    initial begin
        int n;
        resetn        = 1'b0;
        invalidate    = 1'b0;
        sd_rbusy      = 1'b0;
        sd_rdone      = 1'b0;
        sd_outen      = 1'b0;
        sd_outaddr    = '0;
        sd_outbyte    = '0;
        fdc.req       = 1'b0;
        fdc.req_drive = 1'b0;
        fdc.req_lba   = '0;
        fdc.rd_addr   = '0;
        fdc_to.req       = 1'b0;
        fdc_to.req_drive = 1'b0;
        fdc_to.req_lba   = '0;
        fdc_to.rd_addr   = '0;
        tick();
        tick();

        // Reset values
        check("rst_busy",    32'(fdc.busy),    32'd0);
        check("rst_ack",     32'(fdc.ack),     32'd0);
        check("rst_err",     32'(fdc.err),     32'd0);
        check("rst_rd_data", 32'(fdc.rd_data), 32'd0);
        check("rst_rstart",  32'(sd_rstart),   32'd0);
        check("rst_rsector", sd_rsector,       32'd0);
        resetn = 1'b1;
        tick();

        // 1. Cold miss
        send_req(1'b0, 32'd5, 1'b0);
        check("s1_busy", 32'(fdc.busy), 32'd1);
        check("s1_ack_early", 32'(fdc.ack), 32'd0);
        sd_fetch("s1", 32'd5, 2'b01, -1, 32'd0, -1);
        check("s1_ack", 32'(fdc.ack), 32'd1);
        check("s1_busy_done", 32'(fdc.busy), 32'd0);
        fdc.rd_addr = 9'd3;
        tick();
        check("s1_ack_pulse", 32'(fdc.ack), 32'd0);
        check("s1_rd3", 32'(fdc.rd_data), 32'h0A6);
        fdc.rd_addr = 9'd511;
        tick();
        check("s1_rd511", 32'(fdc.rd_data), 32'h05A);

        // 2. Automatic prefetch of lba 6, then a hit on it
        sd_fetch("s2pf6", 32'd6, 2'b01, -1, 32'd0, -1);
        check("s2_pf_ack", 32'(fdc.ack), 32'd0);
        check("s2_pf_busy", 32'(fdc.busy), 32'd0);
        tick();
        tick();
        check("s2_idle_rstart", 32'(sd_rstart), 32'd0);
        send_req(1'b0, 32'd6, 1'b0);
        check("s2_hit_ack", 32'(fdc.ack), 32'd1);
        check("s2_hit_busy", 32'(fdc.busy), 32'd0);
        check("s2_hit_rstart", 32'(sd_rstart), 32'd0);
        fdc.rd_addr = 9'd3;
        tick();
        check("s2_rd3", 32'(fdc.rd_data), 32'h0A5);
        sd_fetch("s2pf7", 32'd7, 2'b01, -1, 32'd0, -1);
        tick();
        tick();
        send_req(1'b0, 32'd6, 1'b0);
        check("s2_rehit_ack", 32'(fdc.ack), 32'd1);
        tick();
        tick();
        check("s2_no_refetch", 32'(sd_rstart), 32'd0);

        // 3a. Request for the sector being prefetched
        do_reset();
        send_req(1'b0, 32'd5, 1'b0);
        sd_fetch("s3a5", 32'd5, 2'b01, -1, 32'd0, -1);
        sd_fetch("s3a6", 32'd6, 2'b01, 100, 32'd6, -1);
        check("s3a_ack", 32'(fdc.ack), 32'd1);
        check("s3a_busy", 32'(fdc.busy), 32'd0);
        fdc.rd_addr = 9'd3;
        tick();
        check("s3a_rd3", 32'(fdc.rd_data), 32'h0A5);

        // 3b. Unrelated request during a prefetch
        do_reset();
        send_req(1'b0, 32'd5, 1'b0);
        sd_fetch("s3b5", 32'd5, 2'b01, -1, 32'd0, -1);
        sd_fetch("s3b6", 32'd6, 2'b01, 50, 32'd40, -1);
        check("s3b_no_ack", 32'(fdc.ack), 32'd0);
        check("s3b_busy", 32'(fdc.busy), 32'd1);
        sd_fetch("s3b40", 32'd40, 2'b01, -1, 32'd0, -1);
        check("s3b_ack", 32'(fdc.ack), 32'd1);
        check("s3b_busy_done", 32'(fdc.busy), 32'd0);
        fdc.rd_addr = 9'd3;
        tick();
        check("s3b_rd3", 32'(fdc.rd_data), 32'h08B);

        // 4. Timeout on the silent-sd_card instance
        fdc_to.req       = 1'b1;
        fdc_to.req_drive = 1'b1;
        fdc_to.req_lba   = 32'd9;
        tick();
        fdc_to.req = 1'b0;
        check("s4_rstart", 32'(sd_rstart_to), 32'd2);
        check("s4_rsector", sd_rsector_to, 32'd9);
        check("s4_busy", 32'(fdc_to.busy), 32'd1);
        n = 0;
        while (!fdc_to.err && n < 300) begin
            if (n == 99) begin
                check("s4_rstart_held", 32'(sd_rstart_to), 32'd2);
            end
            tick();
            n++;
        end
        check("s4_err_cycle", 32'(n), 32'd100);
        check("s4_busy_clr", 32'(fdc_to.busy), 32'd0);
        check("s4_rstart_clr", 32'(sd_rstart_to), 32'd0);
        tick();
        check("s4_err_pulse", 32'(fdc_to.err), 32'd0);

        // 5. Invalidate
        do_reset();
        send_req(1'b0, 32'd5, 1'b0);
        sd_fetch("s5a", 32'd5, 2'b01, -1, 32'd0, -1);
        sd_fetch("s5pf", 32'd6, 2'b01, -1, 32'd0, -1);
        tick();
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        send_req(1'b0, 32'd5, 1'b0);
        check("s5_miss_busy", 32'(fdc.busy), 32'd1);
        sd_fetch("s5b", 32'd5, 2'b01, -1, 32'd0, -1);
        check("s5b_ack", 32'(fdc.ack), 32'd1);
        sd_fetch("s5pf2", 32'd6, 2'b01, -1, 32'd0, -1);
        tick();
        send_req(1'b0, 32'd6, 1'b1);
        check("s5_sim_ack", 32'(fdc.ack), 32'd0);
        check("s5_sim_busy", 32'(fdc.busy), 32'd1);
        check("s5_sim_rstart", 32'(sd_rstart), 32'd1);
        check("s5_sim_rsector", sd_rsector, 32'd6);

        // 6. Reset mid-stream
        do_reset();
        send_req(1'b0, 32'd5, 1'b0);
        sd_fetch("s6", 32'd5, 2'b01, -1, 32'd0, 200);
        check("s6_busy",    32'(fdc.busy),    32'd0);
        check("s6_ack",     32'(fdc.ack),     32'd0);
        check("s6_err",     32'(fdc.err),     32'd0);
        check("s6_rd_data", 32'(fdc.rd_data), 32'd0);
        check("s6_rstart",  32'(sd_rstart),   32'd0);
        check("s6_rsector", sd_rsector,       32'd0);
        resetn = 1'b1;
        tick();
        send_req(1'b0, 32'd5, 1'b0);
        check("s6_miss_busy", 32'(fdc.busy), 32'd1);
        check("s6_miss_rstart", 32'(sd_rstart), 32'd1);
        check("s6_miss_rsector", sd_rsector, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_sector_cache.md
Name: sd_sector_cache

Overview:
- Sits between `sd_card` (sector stream producer) and the floppy controller inside `atarist` (sector consumer).
- Holds two 512-byte sector banks and answers sector requests from the FDC, tagged by drive and LBA.
- Issues reads to `sd_card` on a miss.
- Optionally prefetches the next sequential sector into the spare bank, so track reads stream without per-sector SD latency.

Parameters:
- PREFETCH, 1, 1 = after each served request, fetch lba+1 of the same drive into the spare bank.
- TIMEOUT, 32'd64000000, clk cycles from issuing rstart to required rdone; 2 s at 32 MHz.

Ports:
- clk  in  1  system clock (clk_32).
- resetn  in  1  synchronous active-low reset.
- invalidate  in  1  pulse; image mount changed, drop all tags.
- req  in  1  one-cycle sector request; legal only when busy=0.
- req_drive  in  1  drive index (0=A, 1=B).
- req_lba  in  32  sector number.
- busy  out  1  demand request in progress.
- ack  out  1  one-cycle pulse; requested sector readable.
- err  out  1  one-cycle pulse; request failed (timeout).
- rd_addr  in  9  byte index into the served sector.
- rd_data  out  8  byte at rd_addr, registered.
- sd_rstart  out  2  per-drive read start to sd_card; one-hot.
- sd_rsector  out  32  LBA to sd_card.
- sd_rbusy  in  1  sd_card busy.
- sd_rdone  in  1  sd_card sector complete pulse.
- sd_outen  in  1  byte strobe.
- sd_outaddr  in  9  byte index 0..511.
- sd_outbyte  in  8  byte data.

Behaviour:
- Reset values:
  - busy=0, ack=0, err=0, rd_data=0, sd_rstart=0, sd_rsector=0.
  - Both bank valid bits=0; active bank=0; FSM=IDLE.
- Each bank carries tag {drive, lba} and a valid bit. The active bank is the one being read through rd_addr.
- rd_data = bank[active][rd_addr] with 1-cycle latency.
- FSM states: IDLE, ISSUE, STREAM, FINISH.
- req in IDLE, hit (a valid bank tag matches):
  - active := hit bank.
  - ack 1 cycle after req; busy stays 0.
- req in IDLE, miss:
  - busy=1; target := the non-active bank; that bank's valid := 0; go to ISSUE.
- ISSUE:
  - sd_rsector = lba; sd_rstart[drive] = 1, held until sd_rbusy is sampled high; then go to STREAM.
- STREAM:
  - Each sd_outen writes sd_outbyte to bank[target][sd_outaddr].
  - sd_rdone goes to FINISH.
- FINISH:
  - valid[target] := 1; tag set.
  - If demand: active := target, ack pulse, busy := 0.
  - Go to IDLE.
- Prefetch: one cycle after any ack, if PREFETCH=1 and the spare bank does not already hold {drive, lba+1}:
  - Start a prefetch of lba+1 into the spare bank.
  - No busy, no ack for it.
  - lba+1 wraps modulo 2^32.
- req during prefetch (ISSUE/STREAM):
  - busy := 1 immediately and the request is latched.
  - If its tag equals the prefetch tag: ack 1 cycle after FINISH, with active := that bank.
  - Otherwise: complete the prefetch, then treat the request as a miss. The target is the bank not holding the new tag; hits are re-evaluated after the prefetch.
- The active bank is never a fill target while busy=0. The consumer can keep reading the served sector during a prefetch.
- Timeout: a cycle counter starts at entry to ISSUE. Reaching TIMEOUT before FINISH means:
  - sd_rstart := 0; target bank stays invalid; FSM := IDLE.
  - err pulse if a demand request is pending (busy := 0); a silent drop if prefetch only.
- sd_outen outside STREAM is ignored.
- invalidate:
  - Clears both valid bits the same cycle.
  - A fetch in flight completes its transfer but does not set valid.
  - A pending demand request still gets ack, since data are fresh from the new image.
- resetn low mid-transfer: all state returns to reset values at the next edge, and in-flight bytes are discarded.
- Simultaneous req and invalidate in IDLE: invalidate takes priority, so the request is treated as a miss.

Decomposition:
- Package sd_cache_pkg:
  - FSM state enum.
  - SECTOR_BYTES=512.
  - Tag typedef struct {logic drive; logic [31:0] lba;}.
- One sub-module, sd_cache_bank: 512x8 single-write/single-read synchronous RAM (BSRAM-inferable), instantiated twice.

Test Plan:
1. Cold miss: req drive0 lba 5 → sd_rstart=2'b01, sd_rsector=5.
   - Model streams bytes i^8'hA5 for i=0..511, then rdone.
   - ack 1 cycle after rdone; rd_addr=3 reads 8'hA6 next cycle.
2. Prefetch hit, PREFETCH=1: after scenario 1, rstart automatically issues for lba 6.
   - After completion, req lba 6 → ack 1 cycle later with no new rstart.
   - Prefetch of lba 7 follows.
3. Request during prefetch:
   - req lba 6 mid-stream of prefetch 6 → busy=1, ack 1 cycle after rdone.
   - req lba 40 mid-stream of prefetch 6 → prefetch completes, then rstart with lba 40.
4. Timeout: model never asserts rbusy, TIMEOUT=100 → err pulse exactly 100 cycles after ISSUE entry, busy=0, sd_rstart=0.
5. Invalidate: with lba 5 cached, pulse invalidate then req lba 5 → miss, new rstart issued.
   - Also drive req and invalidate in the same cycle → treated as a miss.
6. Reset mid-STREAM: drop resetn at byte 200 → next cycle all outputs at reset values; a later req lba 5 misses.
